// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller-facing state encoding and the MISR/LFSR
// next-state function used by both the signature analyzer and the pattern generator.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_RESULT  = 2'd3
  } bist_state_e;

  localparam int unsigned MISR_MAX_W = 64;
  typedef logic [MISR_MAX_W-1:0] misr_word_t;

  // Galois-style shift: the bit leaving the MSB folds the polynomial back in,
  // then the parallel input word is XORed on top. Callers zero-extend their
  // operands to misr_word_t and truncate the result back to their own width.
  function automatic misr_word_t misr_next(input misr_word_t  misr,
                                           input misr_word_t  resp,
                                           input misr_word_t  poly,
                                           input int unsigned width);
    misr_word_t mask;
    misr_word_t shifted;
    mask    = (width >= MISR_MAX_W) ? '1 : ((misr_word_t'(1) << width) - misr_word_t'(1));
    shifted = (misr << 1) & mask;
    if (misr[width-1]) shifted = shifted ^ poly;
    return (shifted ^ resp) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: reloads the seed and/or compacts one
// response word per enabled clock.
import bist_pkg::*;

module bist_misr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 'h1D,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed,
  input  logic             step,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] signature
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] next_sig;

  // load_seed together with step compacts onto the seed, so a new run needs no idle cycle.
  always_comb begin
    base     = load_seed ? SEED : signature;
    next_sig = WIDTH'(misr_next(misr_word_t'(base), misr_word_t'(resp),
                                misr_word_t'(POLY), WIDTH));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            signature <= SEED;
    else if (step)      signature <= next_sig;
    else if (load_seed) signature <= SEED;
  end

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response compaction and verdict: MISR over the test run, one compare
// cycle against GOLDEN, then a held pass/fail result until the next run.
import bist_pkg::*;

module bist_signature_analyzer #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY   = 'h1D,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter logic [WIDTH-1:0] GOLDEN = 'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bist_on,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  bist_state_e state, next_state;
  logic        load_seed;
  logic        step;

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (load_seed),
    .step      (step),
    .resp      (resp),
    .signature (signature)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    load_seed  = 1'b0;
    step       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load_seed = 1'b1;
        step      = bist_on;
        if (bist_on) next_state = bist_end ? ST_COMPARE : ST_COMPACT;
      end
      ST_COMPACT: begin
        step = bist_on;
        if (bist_end) begin
          next_state = ST_COMPARE;
        end else if (!bist_on) begin
          // Controller dropped the run without finishing: discard it, no verdict.
          load_seed  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_COMPARE: next_state = ST_RESULT;
      ST_RESULT: begin
        if (bist_on) begin
          load_seed  = 1'b1;
          step       = 1'b1;
          next_state = ST_COMPACT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Signature is frozen during COMPARE, so it is the final compacted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state == ST_COMPARE) begin
      done <= 1'b1;
      pass <= (signature == GOLDEN);
      fail <= (signature != GOLDEN);
    end else if (state == ST_RESULT && bist_on) begin
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Self-checking bench: directed scenarios plus randomized runs, compared every
// cycle against a run-level reference model of the analyzer.
module tb_bist_signature_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bist_on;
  logic       bist_end;
  logic [7:0] resp;

  logic [7:0] sig_a, sig_b;
  logic       done_a, pass_a, fail_a;
  logic       done_b, pass_b, fail_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run phase, signature value and verdict.
  typedef enum int {M_IDLE, M_RUN, M_JUDGE, M_HOLD} mphase_e;
  mphase_e m_ph;
  int      m_sig;
  bit      m_done, m_match_a, m_match_b;

  always #5 clk = ~clk;

  bist_signature_analyzer u_dut (
    .clk (clk), .rst (rst), .bist_on (bist_on), .bist_end (bist_end), .resp (resp),
    .signature (sig_a), .done (done_a), .pass (pass_a), .fail (fail_a)
  );

  bist_signature_analyzer #(.GOLDEN (8'h03)) u_gold (
    .clk (clk), .rst (rst), .bist_on (bist_on), .bist_end (bist_end), .resp (resp),
    .signature (sig_b), .done (done_b), .pass (pass_b), .fail (fail_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Polynomial arithmetic over GF(2): multiply by x, reduce by x^8 + POLY, add input.
  function automatic int ref_step(input int s, input int r);
    int t;
    t = s * 2;
    if (t >= 256) t = (t - 256) ^ 'h1D;
    return t ^ r;
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_sig = 0; m_done = 0; m_match_a = 0; m_match_b = 0;
  endtask

  task automatic model_edge(input bit on, input bit fin, input int r);
    case (m_ph)
      M_IDLE: if (on) begin
        m_sig = ref_step(0, r);
        m_ph  = fin ? M_JUDGE : M_RUN;
      end
      M_RUN: begin
        if (on) m_sig = ref_step(m_sig, r);
        if (fin)      m_ph = M_JUDGE;
        else if (!on) begin m_ph = M_IDLE; m_sig = 0; end
      end
      M_JUDGE: begin
        m_done = 1; m_match_a = (m_sig == 'h5A); m_match_b = (m_sig == 'h03);
        m_ph = M_HOLD;
      end
      M_HOLD: if (on) begin
        m_done = 0; m_match_a = 0; m_match_b = 0;
        m_sig = ref_step(0, r);
        m_ph  = M_RUN;
      end
    endcase
  endtask

  task automatic compare_all();
    check("sig_a",  sig_a,        8'(m_sig));
    check("sig_b",  sig_b,        8'(m_sig));
    check("done_a", {7'd0, done_a}, {7'd0, m_done});
    check("pass_a", {7'd0, pass_a}, {7'd0, m_done &&  m_match_a});
    check("fail_a", {7'd0, fail_a}, {7'd0, m_done && !m_match_a});
    check("pass_b", {7'd0, pass_b}, {7'd0, m_done &&  m_match_b});
    check("fail_b", {7'd0, fail_b}, {7'd0, m_done && !m_match_b});
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare 1 ns later.
  task automatic cyc(input bit on, input bit fin, input logic [7:0] r);
    bist_on = on; bist_end = fin; resp = r;
    @(posedge clk);
    model_edge(on, fin, int'(r));
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; bist_on = 1'b0; bist_end = 1'b0; resp = 8'h00;
    model_reset();
    #12;
    compare_all();
    rst = 1'b0;

    // Basic compaction: 01, 02, 03 -> 01, 00, 03; mismatch on default golden.
    cyc(1, 0, 8'h01); check("basic_s1", sig_a, 8'h01);
    cyc(1, 0, 8'h02); check("basic_s2", sig_a, 8'h00);
    cyc(1, 1, 8'h03); check("basic_s3", sig_a, 8'h03);
    check("basic_no_early_done", {7'd0, done_a}, 8'h00);
    cyc(0, 0, 8'h00);
    check("basic_done", {7'd0, done_a}, 8'h01);
    check("basic_fail", {7'd0, fail_a}, 8'h01);
    check("gold_pass",  {7'd0, pass_b}, 8'h01);

    // Verdict held, bist_end ignored while holding.
    for (int i = 0; i < 10; i++) cyc(0, i[0], 8'($urandom));
    check("gold_pass_held", {7'd0, pass_b}, 8'h01);

    // Restart from result, then feedback tap behaviour.
    cyc(1, 0, 8'h80);
    check("restart_done_clr", {7'd0, done_a}, 8'h00);
    check("restart_sig", sig_a, 8'h80);
    cyc(1, 0, 8'h00); check("feedback", sig_a, 8'h1D);

    // Abort mid-run.
    cyc(0, 0, 8'h77); check("abort_sig", sig_a, 8'h00);
    cyc(0, 0, 8'h00); check("abort_no_done", {7'd0, done_a}, 8'h00);

    // Single-cycle run matching the default golden value.
    cyc(1, 1, 8'h5A);
    cyc(0, 0, 8'h00); check("single_pass", {7'd0, pass_a}, 8'h01);
    cyc(1, 1, 8'h03); check("b2b_clear", {7'd0, done_a}, 8'h00);
    cyc(1, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Asynchronous reset between clock edges during compaction.
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    #2 rst = 1'b1;
    #1;
    check("async_sig",  sig_a, 8'h00);
    check("async_done", {7'd0, done_a}, 8'h00);
    #1 rst = 1'b0;
    model_reset();
    bist_on = 1'b0;
    cyc(0, 0, 8'h00);

    // Randomized runs, with occasional aborts and early ends.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 88), ($urandom_range(0, 99) < 8), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
